rgb_stream_packer: RTL and testbench
====================================

Name: rgb_stream_packer

Overview:
Downstream stage of pixel_generator. Accepts one 24-bit RGB pixel per handshake, with sof/eol markers, and packs the byte stream into 32-bit AXI4-Stream words for the video DMA: 4 pixels become 3 words.
Partial words at end-of-line are flushed with tkeep marking the valid bytes. tuser flags start-of-frame and tlast flags end-of-line.
Sustains 1 pixel/cycle when out_stream_tready is held high.

Parameters:
RGB_ORDER, 0, byte-lane order per pixel: 0 = {b,g,r} in ascending lanes; 1 = {r,g,b} in ascending lanes.

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
r  in  8  red component
g  in  8  green component
b  in  8  blue component
valid  in  1  pixel on r/g/b is valid
sof  in  1  pixel is first of frame; qualified by valid
eol  in  1  pixel is last of line; qualified by valid
in_stream_ready  out  1  packer accepts the pixel this cycle
out_stream_tdata  out  32  packed bytes; lane 0 = earliest byte
out_stream_tkeep  out  4  valid byte lanes
out_stream_tlast  out  1  word ends a line
out_stream_tuser  out  1  word starts a frame
out_stream_tvalid  out  1  output word valid
out_stream_tready  in  1  sink accepts the word

Behaviour:
- Clock and reset: one clock (aclk). Reset (areset) is asynchronous and active-high.
- Accept: pixel accepted when valid && in_stream_ready. Hold: valid/r/g/b/sof/eol must stay stable until accepted.
- Byte buffer: 8-byte FIFO-order buffer with fill count cnt (0..8). An accepted pixel appends 3 bytes in RGB_ORDER.
- Output register: out_stream_* is a registered word. Load condition: load = (!out_stream_tvalid || out_stream_tready) && (cnt>=4 || (eol_pending && cnt>0)).
- On load:
  - tdata = oldest min(cnt,4) bytes, zero-padded in upper lanes.
  - tkeep = 4'hF if cnt>=4, else (1<<cnt)-1.
  - buffer shifts; cnt -= min(cnt,4).
- If load is false and out_stream_tready is high, out_stream_tvalid deasserts next cycle.
- Ready: in_stream_ready = !eol_pending && (cnt<=5 || load). This is combinational from out_stream_tready.
- Same-cycle accept and load: cnt_next = cnt + 3 - 4; no overflow (max cnt 8).
- eol_pending:
  - Set when a pixel with eol=1 is accepted.
  - The word whose load empties the buffer (cnt_next==0) while eol_pending has tlast=1. eol_pending clears on that load.
  - A full word that empties the buffer carries tlast with tkeep=4'hF.
- sof_pending:
  - Set when a pixel with sof=1 is accepted.
  - The next loaded word has tuser=1; sof_pending clears on that load.
  - sof and eol on the same pixel are both honoured.
- Latency: first output word is valid 1 cycle after the load condition is first met. With tready held high, 4 pixels yield 3 words with no input stall beyond the natural pattern.
- Reset values: out_stream_tvalid=0, tdata=32'h0, tkeep=4'h0, tlast=0, tuser=0, cnt=0, eol_pending=0, sof_pending=0. in_stream_ready becomes 1 once reset deasserts.
- Reset mid-operation: buffered bytes and the pending output word are discarded; no partial word is emitted.
- Illegal input: valid with eol while eol_pending cannot occur because ready is low. sof mid-line is passed through as-is; no checking.

Optional Feature:
RGB_PACKER_FORCE_KEEP_EN
- Defined: flush words always drive tkeep=4'hF; padding lanes are 8'h00. Used for DMA cores that reject sparse tkeep.
- Undefined: tkeep reflects valid lanes as described in Behaviour.

Decomposition:
- Package rgb_stream_pkg:
  - BYTES_PER_PIXEL=3, WORD_BYTES=4, BUF_BYTES=8
  - RGB_ORDER encodings
  - typedef rgb_pixel_t (r,g,b)
  - typedef axis_word_t (tdata,tkeep,tlast,tuser)
- No sub-module: buffer, counter and output register live in one module.

Test Plan:
- Four pixels (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C), RGB_ORDER=0, first with sof, last with eol, tready=1 -> words 32'h06010203 (tuser=1), 32'h08090405, 32'h0A0B0C07 (tlast=1), all tkeep=4'hF.
- Two pixels (01,02,03),(04,05,06), second with eol -> 32'h06010203 keep F, then 32'h00000405 keep 4'b0011 tlast=1. With RGB_PACKER_FORCE_KEEP_EN defined, the second word has keep 4'hF.
- 640-pixel line at valid=1, tready=1 -> exactly 480 words; tlast only on word 480; in_stream_ready low only while eol flush drains.
- tready toggled 1/0 every cycle over 8 pixels -> no word lost or duplicated; tdata/tkeep stable while tvalid && !tready.
- areset pulsed after 2 accepted pixels, then 4 new pixels -> no residual bytes; first post-reset word contains only new pixel bytes.
- RGB_ORDER=1, pixel (01,02,03) with eol -> word 32'h00030201, keep 4'b0111, tlast=1.

Source files
------------

// File: rtl/rgb_stream_pkg.sv
// Shared sizes, byte-lane order encodings and bus structs for the RGB stream packer.
// Lane 0 of every lane-packed vector sits in bits [7:0].
package rgb_stream_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int WORD_BYTES      = 4;
  localparam int BUF_BYTES       = 8;

  // Byte-lane order of one pixel in the output stream
  localparam int RGB_ORDER_BGR = 0;  // lanes ascending: b, g, r
  localparam int RGB_ORDER_RGB = 1;  // lanes ascending: r, g, b

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
  } axis_word_t;

  function automatic logic [23:0] pixel_lanes(input rgb_pixel_t p, input int order);
    return (order == RGB_ORDER_RGB) ? {p.b, p.g, p.r} : {p.r, p.g, p.b};
  endfunction

endpackage

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words); eol flushes a partial word.
// Latency: word registered 1 cycle after enough bytes exist; stalls input when the 8-byte buffer cannot take 3 more.
// Optional RGB_PACKER_FORCE_KEEP_EN: flush words carry tkeep=4'hF with zero padding.
module rgb_stream_packer
  import rgb_stream_pkg::*;
#(
  parameter int RGB_ORDER = RGB_ORDER_BGR
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready
);

  logic [BUF_BYTES-1:0][7:0] buf_q, buf_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      eol_pending_q, eol_pending_d;
  logic                      sof_pending_q, sof_pending_d;
  logic                      tvalid_q, tvalid_d;
  axis_word_t                out_q, out_d;

  logic        load, accept, last_word;
  logic [3:0]  take, rem, idx;
  logic [2:0]  wr;
  logic [23:0] pix;

  always_comb begin
    buf_d         = buf_q;
    out_d         = out_q;
    tvalid_d      = tvalid_q;
    idx           = '0;
    wr            = '0;
    pix           = pixel_lanes(rgb_pixel_t'({r, g, b}), RGB_ORDER);

    load            = (!tvalid_q || out_stream_tready) &&
                      ((cnt_q >= 4'd4) || (eol_pending_q && (cnt_q != 4'd0)));
    in_stream_ready = !eol_pending_q && ((cnt_q <= 4'd5) || load);
    accept          = valid && in_stream_ready;

    take      = load ? ((cnt_q >= 4'd4) ? 4'd4 : cnt_q) : 4'd0;
    rem       = cnt_q - take;
    cnt_d     = rem + (accept ? 4'd3 : 4'd0);
    last_word = load && eol_pending_q && (rem == 4'd0);

    // Drop the bytes going out this cycle, then append the new pixel behind the survivors
    for (int i = 0; i < BUF_BYTES; i++) begin
      idx      = 4'(i) + take;
      buf_d[i] = (idx < 4'(BUF_BYTES)) ? buf_q[idx[2:0]] : 8'h00;
    end
    if (accept) begin
      for (int j = 0; j < BYTES_PER_PIXEL; j++) begin
        wr        = rem[2:0] + 3'(j);
        buf_d[wr] = pix[8*j +: 8];
      end
    end

    if (load) begin
      tvalid_d    = 1'b1;
      out_d.tlast = last_word;
      out_d.tuser = sof_pending_q;
      for (int l = 0; l < WORD_BYTES; l++) begin
        out_d.tdata[8*l +: 8] = (4'(l) < take) ? buf_q[l] : 8'h00;
`ifdef RGB_PACKER_FORCE_KEEP_EN
        out_d.tkeep[l] = 1'b1;
`else
        out_d.tkeep[l] = (4'(l) < take);
`endif
      end
    end else if (out_stream_tready) begin
      tvalid_d = 1'b0;
    end

    sof_pending_d = (sof_pending_q && !load) || (accept && sof);
    eol_pending_d = (eol_pending_q && !last_word) || (accept && eol);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      eol_pending_q <= 1'b0;
      sof_pending_q <= 1'b0;
      tvalid_q      <= 1'b0;
      out_q         <= '0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      eol_pending_q <= eol_pending_d;
      sof_pending_q <= sof_pending_d;
      tvalid_q      <= tvalid_d;
      out_q         <= out_d;
    end
  end

  assign out_stream_tdata  = out_q.tdata;
  assign out_stream_tkeep  = out_q.tkeep;
  assign out_stream_tlast  = out_q.tlast;
  assign out_stream_tuser  = out_q.tuser;
  assign out_stream_tvalid = tvalid_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: both byte orders side by side, scoreboard of expected words from a byte-queue model.
// Honours RGB_PACKER_FORCE_KEEP_EN when computing expected tkeep.
module tb_rgb_stream_packer;
  import rgb_stream_pkg::*;

  logic       aclk   = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       valid = 1'b0, sof = 1'b0, eol = 1'b0, tready = 1'b0;

  logic        ready0, ready1;
  logic [31:0] tdata0, tdata1;
  logic [3:0]  tkeep0, tkeep1;
  logic        tlast0, tlast1, tuser0, tuser1, tvalid0, tvalid1;

  always #5 aclk = ~aclk;

  rgb_stream_packer #(.RGB_ORDER(RGB_ORDER_BGR)) dut0 (
    .aclk(aclk), .areset(areset), .r(r), .g(g), .b(b), .valid(valid), .sof(sof), .eol(eol),
    .in_stream_ready(ready0), .out_stream_tdata(tdata0), .out_stream_tkeep(tkeep0),
    .out_stream_tlast(tlast0), .out_stream_tuser(tuser0), .out_stream_tvalid(tvalid0),
    .out_stream_tready(tready)
  );

  rgb_stream_packer #(.RGB_ORDER(RGB_ORDER_RGB)) dut1 (
    .aclk(aclk), .areset(areset), .r(r), .g(g), .b(b), .valid(valid), .sof(sof), .eol(eol),
    .in_stream_ready(ready1), .out_stream_tdata(tdata1), .out_stream_tkeep(tkeep1),
    .out_stream_tlast(tlast1), .out_stream_tuser(tuser1), .out_stream_tvalid(tvalid1),
    .out_stream_tready(tready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: byte queue per lane order, expected words queued per DUT
  logic [7:0] bq0[$], bq1[$];
  axis_word_t exp0[$], exp1[$];
  logic       sofp0 = 1'b0, sofp1 = 1'b0;

  task automatic model_one(input int ord, input logic [7:0] rr, gg, bb, input logic s, e);
    logic [7:0] q[$];
    axis_word_t w;
    logic       u;
    int         n;
    if (ord == 0) begin q = bq0; u = sofp0; end
    else          begin q = bq1; u = sofp1; end
    u = u | s;
    if (ord == 0) begin q.push_back(bb); q.push_back(gg); q.push_back(rr); end
    else          begin q.push_back(rr); q.push_back(gg); q.push_back(bb); end
    while (q.size() >= 4 || (e && q.size() > 0)) begin
      n = (q.size() >= 4) ? 4 : q.size();
      w = '0;
      for (int i = 0; i < n; i++) begin
        w.tdata[8*i +: 8] = q.pop_front();
        w.tkeep[i]        = 1'b1;
      end
`ifdef RGB_PACKER_FORCE_KEEP_EN
      w.tkeep = 4'hF;
`endif
      w.tlast = e && (q.size() == 0);
      w.tuser = u;
      u = 1'b0;
      if (ord == 0) exp0.push_back(w); else exp1.push_back(w);
    end
    if (ord == 0) begin bq0 = q; sofp0 = u; end
    else          begin bq1 = q; sofp1 = u; end
  endtask

  // Monitor: everything sampled on the falling edge, halfway between handshakes
  axis_word_t  w0, w1;
  logic        hold_vld = 1'b0;
  logic [36:0] held;
  logic        cnt_en = 1'b0;
  int          words0 = 0, lasts0 = 0, rdy_low = 0;

  always @(negedge aclk) begin
    if (areset) begin
      hold_vld = 1'b0;
    end else begin
      if (tvalid0 && tready) begin
        w0 = (exp0.size() > 0) ? exp0.pop_front() : axis_word_t'('0);
        chk("word_bgr", {tdata0, tkeep0, tlast0, tuser0}, w0);
        words0++;
        if (tlast0) lasts0++;
      end
      if (tvalid1 && tready) begin
        w1 = (exp1.size() > 0) ? exp1.pop_front() : axis_word_t'('0);
        chk("word_rgb", {tdata1, tkeep1, tlast1, tuser1}, w1);
      end
      if (hold_vld) chk("hold_stable", {tvalid0, tdata0, tkeep0}, held);
      hold_vld = tvalid0 && !tready;
      held     = {tvalid0, tdata0, tkeep0};
      if (cnt_en && !ready0) rdy_low++;
      if (valid && ready0) begin
        model_one(0, r, g, b, sof, eol);
        model_one(1, r, g, b, sof, eol);
      end
    end
  end

  logic tog_en = 1'b0, tready_hold = 1'b0;
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      tready = tog_en ? ~tready : tready_hold;
    end
  end

  task automatic send(input logic [7:0] rr, gg, bb, input logic s, e);
    int t;
    r = rr; g = gg; b = bb; sof = s; eol = e; valid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!ready0 && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!ready0) chk("ready_timeout", ready0, 1);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp0.size() > 0 || exp1.size() > 0) && t < 3000) begin
      @(posedge aclk);
      #1;
      t++;
    end
    chk({tag, "_left_bgr"}, exp0.size(), 0);
    chk({tag, "_left_rgb"}, exp1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", tvalid0, 0);
    chk("rst_tdata", tdata0, 0);
    chk("rst_tkeep", tkeep0, 0);
    chk("rst_tlast", tlast0, 0);
    chk("rst_tuser", tuser0, 0);
    @(posedge aclk);
    #1;
    areset      = 1'b0;
    tready_hold = 1'b1;
    @(negedge aclk);
    chk("post_rst_ready", ready0, 1);
    chk("post_rst_tvalid", tvalid0, 0);
    @(posedge aclk);
    #1;

    // Four pixels, sof first, eol last
    send(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
    send(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    send(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    send(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
    idle(1);
    drain("four_px");

    // Two pixels, eol on the second: partial flush
    send(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    send(8'h04, 8'h05, 8'h06, 1'b0, 1'b1);
    idle(1);
    drain("two_px");

    // Single pixel carrying both sof and eol
    send(8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
    idle(1);
    drain("one_px");

    // Full 640-pixel line at full rate
    words0 = 0; lasts0 = 0; rdy_low = 0; cnt_en = 1'b1;
    for (int i = 0; i < 640; i++)
      send(8'(i), 8'(i + 7), 8'(i * 3), i == 0, i == 639);
    idle(6);
    drain("line");
    cnt_en = 1'b0;
    chk("line_words", words0, 480);
    chk("line_tlast_count", lasts0, 1);
    chk("line_ready_low_cycles", rdy_low, 1);

    // Backpressure toggling every cycle
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++)
      send(8'(8'h20 + i), 8'(8'h40 + i), 8'(8'h60 + i), i == 0, i == 7);
    idle(2);
    drain("toggle");
    tog_en = 1'b0;
    tready_hold = 1'b1;
    idle(2);

    // Reset while two pixels are buffered and a word is held
    tready_hold = 1'b0;
    idle(2);
    send(8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b0);
    send(8'hA4, 8'hA5, 8'hA6, 1'b0, 1'b0);
    idle(3);
    @(negedge aclk);
    chk("pre_rst_held_tvalid", tvalid0, 1);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_tvalid", tvalid0, 0);
    chk("mid_rst_tkeep", tkeep0, 0);
    bq0.delete(); bq1.delete(); exp0.delete(); exp1.delete();
    sofp0 = 1'b0; sofp1 = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    tready_hold = 1'b1;
    idle(1);
    send(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
    send(8'h14, 8'h15, 8'h16, 1'b0, 1'b0);
    send(8'h17, 8'h18, 8'h19, 1'b0, 1'b0);
    send(8'h1A, 8'h1B, 8'h1C, 1'b0, 1'b1);
    idle(2);
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
